// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl_pkg
// Brief    : Shared types and constants for the UART transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  // Requester port identifiers
  localparam logic PORT_ECHO = 1'b0;
  localparam logic PORT_USER = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_if
// Brief    : Requester and transmitter signal bundle of the TX scheduler.
//            master = scheduler side, slave = requesters + transmitter side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_scheduler_if;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       sent;
  logic       sent_port;
  logic       timeout_err;

  modport master (
    input  req_valid, req_data0, req_data1, tx_busy,
    output req_ready, tx_data, tx_start, sent, sent_port, timeout_err
  );

  modport slave (
    output req_valid, req_data0, req_data1, tx_busy,
    input  req_ready, tx_data, tx_start, sent, sent_port, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_arbiter
// Brief    : Combinational 2-way round-robin pick. The last-grant memory is
//            owned by the caller so the choice only commits on a real launch.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter
  import uart_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // On a tie the port that did not win last time is chosen
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_ECHO;
    if (&req) begin
      gnt_id = ~last_grant;
    end else if (req[1]) begin
      gnt_id = PORT_USER;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Shares one UART transmitter between the echo path (port 0) and
//            the user path (port 1). Holds a level start until the slow
//            transmitter answers with busy, then waits for frame completion.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_scheduler_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_q;
  logic             last_grant_q;
  logic [1:0]       req_ready_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             sent_q;
  logic             sent_port_q;
  logic             timeout_q;

  logic             w_gnt_valid;
  logic             w_gnt_id;

  uart_rr_arbiter u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  // Scheduler FSM; every output is a register so nothing is combinational
  // from the requesters or the transmitter to the outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= PORT_ECHO;
      last_grant_q <= PORT_USER;   // port 0 wins the first tie
      req_ready_q  <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      sent_q       <= 1'b0;
      sent_port_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      req_ready_q <= '0;
      sent_q      <= 1'b0;
      timeout_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Busy guard keeps us off a frame left running across a reset
          if (w_gnt_valid && !bus.tx_busy) begin
            tx_data_q    <= w_gnt_id ? bus.req_data1 : bus.req_data0;
            grant_q      <= w_gnt_id;
            last_grant_q <= w_gnt_id;
            req_ready_q  <= {w_gnt_id, ~w_gnt_id};
            tx_start_q   <= 1'b1;
            cnt_q        <= '0;
            state_q      <= LAUNCH;
          end
        end
        LAUNCH: begin
          // Busy wins over an expiry in the same cycle
          if (bus.tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            sent_q      <= 1'b1;
            sent_port_q <= grant_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.sent        = sent_q;
  assign bus.sent_port   = sent_port_q;
  assign bus.timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Transaction-level bench for uart_tx_scheduler. Requesters keep
//            pending bytes, a transmitter stand-in answers tx_start after a
//            chosen delay, and each frame is predicted from the round-robin
//            rule and the cycle timing of the handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Requester model: pending flag and byte per port, plus round-robin memory
  bit       pend [2];
  bit [7:0] pdata[2];
  bit       model_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req();
    bus.req_valid = {pend[1], pend[0]};
    bus.req_data0 = pdata[0];
    bus.req_data1 = pdata[1];
  endtask

  // fill: 0 keep current, 1 random new bytes, 2 keep both ports busy
  task automatic refill(input int fill);
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && (fill == 2 || (fill == 1 && $urandom_range(0, 1) == 1))) begin
        pend[p]  = 1'b1;
        pdata[p] = 8'($urandom);
      end
    end
    if (fill != 0 && !pend[0] && !pend[1]) begin
      int p = $urandom_range(0, 1);
      pend[p]  = 1'b1;
      pdata[p] = 8'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},   32'(bus.req_ready),   32'd0);
    check_eq({tag, "_txdata"},  32'(bus.tx_data),     32'h00);
    check_eq({tag, "_start"},   32'(bus.tx_start),    32'd0);
    check_eq({tag, "_sent"},    32'(bus.sent),        32'd0);
    check_eq({tag, "_sentp"},   32'(bus.sent_port),   32'd0);
    check_eq({tag, "_timeout"}, 32'(bus.timeout_err), 32'd0);
  endtask

  // One frame, entered and left at a negedge on which the DUT is idle
  task automatic run_txn(input int fill, input bit to_mode, input int d,
                         input int len, input int guard, input bit do_rst);
    int  hi;
    bit  exp;
    if (guard > 0) bus.tx_busy = 1'b1;
    refill(fill);
    drive_req();
    if (guard > 0) begin
      for (int i = 0; i < guard; i++) begin
        @(negedge clk);
        check_eq("guard_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.tx_busy = 1'b0;
    end
    exp = (pend[0] && pend[1]) ? ~model_last : pend[1];
    model_last = exp;

    @(negedge clk);
    check_eq("launch_ready",  32'(bus.req_ready), 32'(exp ? 2'b10 : 2'b01));
    check_eq("launch_data",   32'(bus.tx_data),   32'(pdata[exp]));
    check_eq("launch_start",  32'(bus.tx_start),  32'd1);
    check_eq("launch_quiet",  32'({bus.sent, bus.timeout_err}), 32'd0);
    pend[exp] = 1'b0;
    drive_req();

    if (do_rst) begin
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      model_last = 1'b1;
      rst_n = 1'b1;
      return;
    end

    hi = 1;
    if (to_mode) begin
      for (int i = 0; i < TO + 4; i++) begin
        @(negedge clk);
        if (i == 0) check_eq("ready_pulse", 32'(bus.req_ready), 32'd0);
        if (bus.tx_start) hi++;
        else break;
      end
      check_eq("to_start_len", 32'(hi), 32'(TO));
      check_eq("to_err",       32'(bus.timeout_err), 32'd1);
      check_eq("to_no_sent",   32'(bus.sent), 32'd0);
    end else begin
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        if (i == 0) check_eq("ready_pulse", 32'(bus.req_ready), 32'd0);
        if (bus.tx_start) hi++;
      end
      bus.tx_busy = 1'b1;
      @(negedge clk);
      check_eq("start_fall",    32'(bus.tx_start), 32'd0);
      check_eq("start_len",     32'(hi), 32'(d + 1));
      check_eq("busy_no_to",    32'(bus.timeout_err), 32'd0);
      for (int i = 1; i < len; i++) @(negedge clk);
      check_eq("busy_no_sent",  32'(bus.sent), 32'd0);
      bus.tx_busy = 1'b0;
      @(negedge clk);
      check_eq("sent",      32'(bus.sent), 32'd1);
      check_eq("sent_port", 32'(bus.sent_port), 32'(exp));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;
    bus.tx_busy   = 1'b0;
    pend          = '{1'b0, 1'b0};
    pdata         = '{8'h00, 8'h00};
    model_last    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Tie straight after reset: port 0 then port 1
    pend  = '{1'b1, 1'b1};
    pdata = '{8'h11, 8'h22};
    run_txn(0, 1'b0, 2, 4, 0, 1'b0);
    run_txn(0, 1'b0, 3, 2, 0, 1'b0);

    // Single request, busy answers after 5 cycles and lasts 20
    pend[0] = 1'b1; pdata[0] = 8'h41;
    run_txn(0, 1'b0, 5, 20, 0, 1'b0);

    // Start timeout, then busy arriving exactly on the expiry cycle
    run_txn(1, 1'b1, 0, 0, 0, 1'b0);
    run_txn(1, 1'b0, TO - 1, 3, 0, 1'b0);

    // Transmitter still busy when a request appears
    run_txn(1, 1'b0, 1, 3, 4, 1'b0);

    // Reset during launch, then a tie must go to port 0
    run_txn(1, 1'b0, 0, 0, 0, 1'b1);
    pend  = '{1'b1, 1'b1};
    pdata = '{8'h5a, 8'ha5};
    run_txn(0, 1'b0, 1, 1, 0, 1'b0);

    // Sustained contention over six frames
    for (int i = 0; i < 6; i++) run_txn(2, 1'b0, $urandom_range(0, 4), $urandom_range(1, 6), 0, 1'b0);

    // Randomised mix
    for (int i = 0; i < 40; i++) begin
      run_txn(1,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 6),
              $urandom_range(1, 8),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              $urandom_range(0, 11) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
